addr_mode_sequencer: RTL and testbench
======================================

Name: addr_mode_sequencer

Overview:
- Parametrised operand-fetch and effective-address sequencer for the 6502 core.
- Takes the decoded addressing mode from instruction_decode and fetches 0-2 operand bytes via PC increments.
- Applies X/Y indexing with zero-page wrap and page-cross fixup, then hands a stable effective address (EA) back to the decoder with a done pulse.
- Generalises the decoder's hard-coded ZPG/ZPG_X/ABS paths to ZPG_Y, ABS_X/ABS_Y, immediate, configurable address width and page-cross penalty.

Parameters:
- ADDR_WIDTH, 16, width of EA and bus address; must be >= 16; bits above 15 always driven 0.
- DATA_WIDTH, 8, operand/index width; page size is 2^DATA_WIDTH.
- ZP_WRAP, 1, 1: zero-page indexed sums wrap within page 0; 0: carry propagates into bit DATA_WIDTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_enable  in  1  gates every state/register update
- start  in  1  request; sampled only in IDLE with clk_enable=1
- mode  in  3  0 IMPL, 1 IMM, 2 ZPG, 3 ZPG_X, 4 ZPG_Y, 5 ABS, 6 ABS_X, 7 ABS_Y; sampled with start
- is_write  in  1  store/RMW access; forces fixup cycle on ABS_X/ABS_Y; sampled with start
- data_in  in  DATA_WIDTH  instruction/data bus byte at current PC
- index_x  in  DATA_WIDTH  X register value
- index_y  in  DATA_WIDTH  Y register value
- pc_inc  out  1  increment PC this cycle
- busy  out  1  high in any state except IDLE
- done  out  1  one enabled-cycle pulse; ea/operand valid
- ea  out  ADDR_WIDTH  effective address, held until next start
- operand  out  DATA_WIDTH  immediate byte (mode IMM), held until next start
- page_cross  out  1  last indexed ABS add carried out of low byte
- bus_rd  out  1  dummy-read strobe (optional feature only)
- bus_addr  out  ADDR_WIDTH  dummy-read address (optional feature only)

Behaviour:
- Reset (asynchronous, any state, including mid-sequence):
  - state=IDLE.
  - All outputs 0: pc_inc, busy, done, ea, operand, page_cross, bus_rd, bus_addr.
- States: IDLE, FETCH_LO, FETCH_HI, INDEX, FIXUP, DONE. All transitions and captures occur only on clk edges with clk_enable=1. With clk_enable=0, state and all registered outputs hold and combinational outputs remain consistent with the held state.
- IDLE:
  - start=1 and mode=IMPL -> DONE; ea and operand both cleared to 0.
  - start=1 and any other mode -> FETCH_LO.
  - start is ignored while busy.
- FETCH_LO: pc_inc=1; lo<=data_in.
  - IMM: operand<=data_in -> DONE.
  - ZPG -> DONE.
  - ZPG_X/ZPG_Y -> INDEX.
  - ABS* -> FETCH_HI.
- INDEX:
  - ZP_WRAP=1: ea = zero-extended (lo+idx) mod 2^DATA_WIDTH.
  - ZP_WRAP=0: ea = zero-extended full (DATA_WIDTH+1)-bit sum.
  - -> DONE.
- FETCH_HI: pc_inc=1; hi<=data_in.
  - ABS: ea={hi,lo} -> DONE.
  - ABS_X/ABS_Y: compute {c,s}=lo+idx; ea low<=s, ea high<=hi; page_cross<=c.
    - c=1 or is_write=1 -> FIXUP.
    - Otherwise -> DONE.
- FIXUP: ea high<=hi+page_cross, wrapping mod 2^(16-DATA_WIDTH) within the 16-bit space -> DONE.
- DONE: done=1 for exactly one enabled cycle -> IDLE. A start in the following IDLE cycle is accepted, giving back-to-back operation.
- Index select: X for ZPG_X/ABS_X, Y for ZPG_Y/ABS_Y, sampled in the cycle it is used.
- Enabled-cycle counts from start acceptance to done (inclusive):
  - IMPL 2; IMM 3; ZPG 3; ZPG_X/Y 4; ABS 4.
  - ABS_X/Y 4 with no cross and read; 5 with cross or write.
- page_cross is cleared to 0 on start for non-ABS_X/Y modes.
- Wrap-around: ea 0xFFFF + X fixup wraps to 0x00xx. No out-of-range value appears above bit 15.

Optional Feature:
- Macro ADDR_MODE_SEQ_DUMMY_READ_EN.
- Defined: in FIXUP, bus_rd=1 and bus_addr={hi, s} (unfixed address), matching NMOS 6502 bus activity. Both are 0 in every other state.
- Undefined: bus_rd and bus_addr tied to 0; FIXUP timing unchanged.

Test Plan:
- Reset mid-sequence: start mode=ABS_X, assert rst_n=0 while in FETCH_HI -> immediate IDLE, all outputs 0, busy=0; next start behaves normally.
- ZPG_X wrap: ZP_WRAP=1, data_in=0xF0, X=0x20 -> done on 4th enabled cycle, ea=0x0010, pc_inc high for exactly 1 cycle. With ZP_WRAP=0 -> ea=0x0110.
- ABS_Y no cross, read: bytes 0x34,0x12, Y=0x05, is_write=0 -> ea=0x1239, page_cross=0, 4 cycles, 2 pc_inc pulses.
- ABS_X cross: bytes 0xFF,0x12, X=0x01 -> FIXUP taken, ea=0x1300, page_cross=1, 5 cycles. With DUMMY_READ_EN: bus_rd pulse at 0x1200.
- Write forces fixup: ABS_X 0x00,0x20, X=0x01, is_write=1 -> 5 cycles, ea=0x2001, page_cross=0.
- clk_enable stall plus back-to-back: IMM 0xA9 with clk_enable toggling 1/0 -> operand=0xA9, done lasts exactly one enabled cycle; start in next IDLE cycle accepted with no lost cycle.

Source files
------------

// File: rtl/addr_mode_sequencer.sv
// -----------------------------------------------------------------------------
// addr_mode_sequencer
//
// Operand-fetch and effective-address sequencer for the 6502 core. On an
// accepted start it fetches 0-2 operand bytes from the instruction stream
// (one pc_inc per byte), applies X/Y indexing with zero-page wrap and
// page-cross fixup, and presents a stable effective address with a one
// enabled-cycle done pulse.
//
// Parameters:
//   ADDR_WIDTH  width of ea / bus_addr (>= 16); bits above 15 are always 0
//   DATA_WIDTH  operand / index width; a page is 2^DATA_WIDTH bytes
//   ZP_WRAP     1: zero-page indexed sums wrap inside page 0
//               0: the carry lands in bit DATA_WIDTH of ea
//
// Optional feature (macro ADDR_MODE_SEQ_DUMMY_READ_EN):
//   defined   -> bus_rd/bus_addr show the NMOS dummy read of the unfixed
//                address during FIXUP
//   undefined -> bus_rd and bus_addr are tied to 0
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clk_enable   gates every state/register update
//   start, mode, is_write   request, addressing mode, store/RMW flag
//   data_in      byte at the current PC
//   index_x/y    index registers, read in the cycle they are used
//   pc_inc       advance PC this cycle
//   busy, done   sequencer active / result valid pulse
//   ea, operand, page_cross   results, held until the next start
//   bus_rd, bus_addr          dummy-read strobe and address
// -----------------------------------------------------------------------------
module addr_mode_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter bit ZP_WRAP    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_enable,
    input  logic                  start,
    input  logic [2:0]            mode,
    input  logic                  is_write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] index_x,
    input  logic [DATA_WIDTH-1:0] index_y,
    output logic                  pc_inc,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ea,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  page_cross,
    output logic                  bus_rd,
    output logic [ADDR_WIDTH-1:0] bus_addr
);

    typedef enum logic [2:0] {
        M_IMPL  = 3'd0,
        M_IMM   = 3'd1,
        M_ZPG   = 3'd2,
        M_ZPG_X = 3'd3,
        M_ZPG_Y = 3'd4,
        M_ABS   = 3'd5,
        M_ABS_X = 3'd6,
        M_ABS_Y = 3'd7
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_LO,
        S_FETCH_HI,
        S_INDEX,
        S_FIXUP,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    mode_e                 mode_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [15:0]           ea_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  page_cross_q;

    logic [DATA_WIDTH-1:0] idx;
    logic [DATA_WIDTH:0]   sum;
    logic [15:0]           hi_part;
    logic                  mode_is_abs_idx;

    // Index register follows the captured mode; X for *_X, Y for *_Y.
    assign idx = (mode_q == M_ZPG_X || mode_q == M_ABS_X) ? index_x : index_y;
    assign sum = {1'b0, lo_q} + {1'b0, idx};

    // The high operand byte lands above the page-offset bits; the shift drops
    // anything that would fall outside the 16-bit address space.
    assign hi_part = 16'(data_in) << DATA_WIDTH;

    assign mode_is_abs_idx = (mode == M_ABS_X) || (mode == M_ABS_Y);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (mode == M_IMPL) ? S_DONE : S_FETCH_LO;
                end
            end
            S_FETCH_LO: begin
                pc_inc = 1'b1;
                unique case (mode_q)
                    M_IMM, M_ZPG:     state_d = S_DONE;
                    M_ZPG_X, M_ZPG_Y: state_d = S_INDEX;
                    default:          state_d = S_FETCH_HI;
                endcase
            end
            S_FETCH_HI: begin
                pc_inc = 1'b1;
                if (mode_q == M_ABS) begin
                    state_d = S_DONE;
                end else begin
                    // A store must never touch the unfixed address, so it
                    // always pays the fixup cycle.
                    state_d = (sum[DATA_WIDTH] || write_q) ? S_FIXUP : S_DONE;
                end
            end
            S_INDEX: state_d = S_DONE;
            S_FIXUP: state_d = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= M_IMPL;
            write_q      <= 1'b0;
            lo_q         <= '0;
            ea_q         <= '0;
            operand_q    <= '0;
            page_cross_q <= 1'b0;
        end else if (clk_enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q    <= mode_e'(mode);
                        write_q   <= is_write;
                        ea_q      <= '0;
                        operand_q <= '0;
                        if (!mode_is_abs_idx) begin
                            page_cross_q <= 1'b0;
                        end
                    end
                end
                S_FETCH_LO: begin
                    lo_q <= data_in;
                    if (mode_q == M_IMM) begin
                        operand_q <= data_in;
                    end
                    if (mode_q == M_ZPG) begin
                        ea_q <= 16'(data_in);
                    end
                end
                S_INDEX: begin
                    if (ZP_WRAP) begin
                        ea_q <= 16'(sum[DATA_WIDTH-1:0]);
                    end else begin
                        ea_q <= 16'(sum);
                    end
                end
                S_FETCH_HI: begin
                    if (mode_q == M_ABS) begin
                        ea_q <= hi_part | 16'(lo_q);
                    end else begin
                        ea_q         <= hi_part | 16'(sum[DATA_WIDTH-1:0]);
                        page_cross_q <= sum[DATA_WIDTH];
                    end
                end
                S_FIXUP: begin
                    // Carry into the page number; the 16-bit add wraps
                    // 0xFFxx + 1 page back to page 0.
                    ea_q <= ea_q + (16'(page_cross_q) << DATA_WIDTH);
                end
                default: ;
            endcase
        end
    end

    assign ea         = ADDR_WIDTH'(ea_q);
    assign operand    = operand_q;
    assign page_cross = page_cross_q;

`ifdef ADDR_MODE_SEQ_DUMMY_READ_EN
    // During FIXUP ea still holds {hi, s}: the address the NMOS part reads
    // before it has corrected the page.
    assign bus_rd   = (state_q == S_FIXUP);
    assign bus_addr = bus_rd ? ADDR_WIDTH'(ea_q) : '0;
`else
    assign bus_rd   = 1'b0;
    assign bus_addr = '0;
`endif

endmodule

// File: tb/tb_addr_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_addr_mode_sequencer
//
// Self-checking bench for addr_mode_sequencer. Two instances share stimulus:
// dut (ZP_WRAP=1) and dut_nw (ZP_WRAP=0). A table of directed operations with
// hand-computed results, a mid-sequence reset sequence, and randomized
// operations checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_addr_mode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_enable = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic        is_write = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  index_x = 8'h00;
    logic [7:0]  index_y = 8'h00;

    logic        pc_inc, busy, done, page_cross, bus_rd;
    logic [15:0] ea, bus_addr;
    logic [7:0]  operand;

    logic        nw_pc_inc, nw_busy, nw_done, nw_page_cross, nw_bus_rd;
    logic [15:0] nw_ea, nw_bus_addr;
    logic [7:0]  nw_operand;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    addr_mode_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ZP_WRAP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .start(start),
        .mode(mode), .is_write(is_write), .data_in(data_in),
        .index_x(index_x), .index_y(index_y), .pc_inc(pc_inc), .busy(busy),
        .done(done), .ea(ea), .operand(operand), .page_cross(page_cross),
        .bus_rd(bus_rd), .bus_addr(bus_addr)
    );

    addr_mode_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ZP_WRAP(1'b0)) dut_nw (
        .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .start(start),
        .mode(mode), .is_write(is_write), .data_in(data_in),
        .index_x(index_x), .index_y(index_y), .pc_inc(nw_pc_inc), .busy(nw_busy),
        .done(nw_done), .ea(nw_ea), .operand(nw_operand), .page_cross(nw_page_cross),
        .bus_rd(nw_bus_rd), .bus_addr(nw_bus_addr)
    );

    typedef struct {
        int mode;
        int wr;
        int b0;
        int b1;
        int x;
        int y;
        bit stall;
    } op_t;

    typedef struct {
        int ea;
        int ea_nw;
        int operand;
        int pc;
        int cyc;
        int pcs;
    } res_t;

    typedef struct {
        op_t  op;
        res_t exp;
    } vec_t;

    typedef struct {
        res_t r;
        int   rd_n;
        int   rd_addr;
        bit   seq_bad;
        bit   fin;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: results straight from the addressing-mode rules.
    function automatic res_t model(input op_t op);
        res_t r;
        int   i;
        int   full;
        r = '{0, 0, 0, 0, 0, 0};
        i = (op.mode == 3 || op.mode == 6) ? op.x : op.y;
        case (op.mode)
            0: r.cyc = 2;
            1: begin r.operand = op.b0; r.cyc = 3; r.pcs = 1; end
            2: begin r.ea = op.b0; r.ea_nw = op.b0; r.cyc = 3; r.pcs = 1; end
            3, 4: begin
                r.ea    = (op.b0 + i) % 256;
                r.ea_nw = op.b0 + i;
                r.cyc   = 4;
                r.pcs   = 1;
            end
            5: begin
                r.ea = op.b1 * 256 + op.b0; r.ea_nw = r.ea; r.cyc = 4; r.pcs = 2;
            end
            default: begin
                full    = op.b1 * 256 + op.b0 + i;
                r.ea    = full % 65536;
                r.ea_nw = r.ea;
                r.pc    = (op.b0 + i > 255) ? 1 : 0;
                r.cyc   = (r.pc == 1 || op.wr == 1) ? 5 : 4;
                r.pcs   = 2;
            end
        endcase
        return r;
    endfunction

    // Drive one operation from start acceptance through the enabled done
    // cycle. Returns at the falling edge of the done cycle, so a following
    // call issues start in the very next IDLE cycle.
    task automatic run_op(input op_t op, output obs_t o);
        int guard = 0;
        bit accepted = 1'b0;
        o.r       = '{0, 0, 0, 0, 0, 0};
        o.rd_n    = 0;
        o.rd_addr = 0;
        o.seq_bad = 1'b0;
        o.fin     = 1'b0;
        while (!o.fin && guard < 100) begin
            @(negedge clk);
            clk_enable = op.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = !accepted;
            mode       = 3'(op.mode);
            is_write   = 1'(op.wr);
            index_x    = 8'(op.x);
            index_y    = 8'(op.y);
            data_in    = (o.r.pcs == 0) ? 8'(op.b0) : 8'(op.b1);
            #1;
            if (clk_enable) begin
                o.r.cyc++;
                if (!accepted) begin
                    if (busy || done || pc_inc) o.seq_bad = 1'b1;
                    accepted = 1'b1;
                end else if (!busy) begin
                    o.seq_bad = 1'b1;
                end
                if (pc_inc) o.r.pcs++;
                if (bus_rd) begin
                    o.rd_n++;
                    o.rd_addr = int'(bus_addr);
                end
                if (done) begin
                    o.fin       = 1'b1;
                    o.r.ea      = int'(ea);
                    o.r.ea_nw   = int'(nw_ea);
                    o.r.operand = int'(operand);
                    o.r.pc      = int'(page_cross);
                end
            end
            guard++;
        end
    endtask

    task automatic compare_op(input string tag, input op_t op, input res_t exp, input obs_t o);
        int i;
        int exp_rd_n;
        int exp_rd_addr;
        i = (op.mode == 3 || op.mode == 6) ? op.x : op.y;
`ifdef ADDR_MODE_SEQ_DUMMY_READ_EN
        exp_rd_n    = (exp.cyc == 5) ? 1 : 0;
        exp_rd_addr = (exp.cyc == 5) ? (op.b1 * 256 + ((op.b0 + i) % 256)) : 0;
`else
        exp_rd_n    = 0;
        exp_rd_addr = 0 * i;
`endif
        check({tag, "_done_seen"}, 32'(o.fin), 32'd1);
        check({tag, "_ea"}, 32'(o.r.ea), 32'(exp.ea));
        check({tag, "_ea_nowrap"}, 32'(o.r.ea_nw), 32'(exp.ea_nw));
        check({tag, "_operand"}, 32'(o.r.operand), 32'(exp.operand));
        check({tag, "_page_cross"}, 32'(o.r.pc), 32'(exp.pc));
        check({tag, "_cycles"}, 32'(o.r.cyc), 32'(exp.cyc));
        check({tag, "_pc_incs"}, 32'(o.r.pcs), 32'(exp.pcs));
        check({tag, "_busy_seq"}, 32'(o.seq_bad), 32'd0);
        check({tag, "_dummy_rds"}, 32'(o.rd_n), 32'(exp_rd_n));
        check({tag, "_dummy_addr"}, 32'(o.rd_addr), 32'(exp_rd_addr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_pc_inc"}, 32'(pc_inc), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ea"}, 32'(ea), 32'd0);
        check({tag, "_operand"}, 32'(operand), 32'd0);
        check({tag, "_page_cross"}, 32'(page_cross), 32'd0);
        check({tag, "_bus_rd"}, 32'(bus_rd), 32'd0);
        check({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
        check({tag, "_nw_ea"}, 32'(nw_ea), 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        obs_t o;
        op_t  op;

        //            mode wr  b0     b1     x      y      stall   ea       ea_nw    op     pc cyc pcs
        vecs[0]  = '{'{3, 0, 'hF0, 'h00, 'h20, 'h00, 1'b0}, '{'h0010, 'h0110, 0,     0, 4, 1}};
        vecs[1]  = '{'{7, 0, 'h34, 'h12, 'h00, 'h05, 1'b0}, '{'h1239, 'h1239, 0,     0, 4, 2}};
        vecs[2]  = '{'{6, 0, 'hFF, 'h12, 'h01, 'h00, 1'b0}, '{'h1300, 'h1300, 0,     1, 5, 2}};
        vecs[3]  = '{'{6, 1, 'h00, 'h20, 'h01, 'h00, 1'b0}, '{'h2001, 'h2001, 0,     0, 5, 2}};
        vecs[4]  = '{'{1, 0, 'hA9, 'h00, 'h00, 'h00, 1'b1}, '{'h0000, 'h0000, 'hA9, 0, 3, 1}};
        vecs[5]  = '{'{1, 0, 'h55, 'h00, 'h00, 'h00, 1'b0}, '{'h0000, 'h0000, 'h55, 0, 3, 1}};
        vecs[6]  = '{'{0, 0, 'h11, 'h22, 'h00, 'h00, 1'b0}, '{'h0000, 'h0000, 0,     0, 2, 0}};
        vecs[7]  = '{'{2, 0, 'h42, 'h00, 'h00, 'h00, 1'b0}, '{'h0042, 'h0042, 0,     0, 3, 1}};
        vecs[8]  = '{'{5, 0, 'h78, 'h56, 'h00, 'h00, 1'b0}, '{'h5678, 'h5678, 0,     0, 4, 2}};
        vecs[9]  = '{'{6, 0, 'hFF, 'hFF, 'h01, 'h00, 1'b0}, '{'h0000, 'h0000, 0,     1, 5, 2}};
        vecs[10] = '{'{4, 0, 'h80, 'h00, 'h00, 'h10, 1'b0}, '{'h0090, 'h0090, 0,     0, 4, 1}};
        vecs[11] = '{'{3, 0, 'hFF, 'h00, 'hFF, 'h00, 1'b0}, '{'h00FE, 'h01FE, 0,     0, 4, 1}};

        // Reset state.
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, issued back to back.
        foreach (vecs[k]) begin
            run_op(vecs[k].op, o);
            compare_op($sformatf("vec%0d", k), vecs[k].op, vecs[k].exp, o);
        end

        // Reset while in FETCH_HI of an ABS_X sequence.
        @(negedge clk);
        clk_enable = 1'b1;
        start = 1'b1; mode = 3'd6; is_write = 1'b0; index_x = 8'h01; data_in = 8'h10;
        @(negedge clk);
        start = 1'b0; data_in = 8'h20;
        @(negedge clk);
        #1;
        check("midrst_pre_busy", 32'(busy), 32'd1);
        check("midrst_pre_pc_inc", 32'(pc_inc), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        op = '{6, 0, 'hFF, 'h12, 'h01, 'h00, 1'b0};
        run_op(op, o);
        compare_op("post_rst", op, model(op), o);

        // Randomized operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            op.mode  = int'($urandom_range(0, 7));
            op.wr    = int'($urandom_range(0, 1));
            op.b0    = int'($urandom_range(0, 255));
            op.b1    = int'($urandom_range(0, 255));
            op.x     = int'($urandom_range(0, 255));
            op.y     = int'($urandom_range(0, 255));
            op.stall = 1'($urandom_range(0, 1));
            run_op(op, o);
            compare_op($sformatf("rnd%0d_m%0d", n, op.mode), op, model(op), o);
        end

        @(negedge clk);
        start = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
